// File: rtl/mem_responder.sv
// mem_responder: word memory behind a req/ack handshake with programmable wait states.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for req; captures writeEnable/address/dataIn on req
// ST_WAIT | counting down wait states; the access happens on leaving
// ST_RESP | ack (and error) high for this single cycle; dataOut valid
//
// A misaligned request also passes through ST_WAIT, but with the counter
// forced to zero. That gives a one-edge gap between capture and response.
// The array is never touched on that path.
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        writeEnable,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic        ack,
    output logic [31:0] dataOut,
    output logic        error
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              we_q;
    logic              mis_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       din_q;
    logic [31:0]       mem [DEPTH];
    logic              capture;
    logic              fire;
    logic              misaligned;
    logic              unused_addr_hi;

    assign misaligned = (address[1:0] != 2'b00);
    assign capture    = (state_q == ST_IDLE) && req;
    // fire marks the WAIT->RESP edge, the only edge where the array is accessed
    assign fire       = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // Upper address bits are ignored, so accesses wrap modulo DEPTH words
    assign unused_addr_hi = ^address[31:IDX_W+2];

    // State and wait counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WAIT;
                    cnt_d   = misaligned ? 4'd0 : WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request capture; later input changes are ignored until the next IDLE edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q  <= 1'b0;
            mis_q <= 1'b0;
            idx_q <= '0;
            din_q <= 32'd0;
        end else if (capture) begin
            we_q  <= writeEnable;
            mis_q <= misaligned;
            idx_q <= address[IDX_W+1:2];
            din_q <= dataIn;
        end
    end

    // Registered response outputs; dataOut holds between responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack     <= 1'b0;
            error   <= 1'b0;
            dataOut <= 32'd0;
        end else begin
            ack   <= fire;
            error <= fire && mis_q;
            if (fire) begin
                if (mis_q) begin
                    dataOut <= 32'd0;
                end else if (we_q) begin
                    dataOut <= din_q;
                end else begin
                    dataOut <= mem[idx_q];
                end
            end
        end
    end

    // Array write; contents survive reset, and a reset before fire drops the write
    always_ff @(posedge clk) begin
        if (fire && !mis_q && we_q) begin
            mem[idx_q] <= din_q;
        end
    end

endmodule
